// File: rtl/mem_program_loader.sv
// Byte-stream program loader: packs bytes big-endian into 32-bit words and writes them
// to consecutive word addresses of Memory, holding the CPU in reset until the image is in.
module mem_program_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_din,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_reset_n,
  output logic [1:0]        state_dbg
);

  // Byte handshake: a byte transfers on a rising edge where in_valid && in_ready are both 1;
  // in_ready depends only on state, never on in_valid.
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   num_q;
  logic [ADDR_W:0]   word_cnt;
  logic [1:0]        byte_cnt;
  logic [23:0]       shift_q;
  logic [ADDR_W+1:0] end_addr;
  logic [ADDR_W-1:0] word_addr;
  logic              range_bad;
  logic              accept;
  logic              last_word;

  assign end_addr  = {2'b0, base_addr} + {1'b0, num_words};
  assign range_bad = end_addr > (ADDR_W+2)'(MAX_WORDS);
  assign word_addr = base_q + word_cnt[ADDR_W-1:0];
  assign accept    = in_valid && in_ready;
  assign last_word = (word_cnt == num_q - (ADDR_W+1)'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (num_words == '0) state_nxt = S_DONE;
          else if (range_bad)  state_nxt = S_IDLE;
          else                 state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: if (accept && byte_cnt == 2'd3) state_nxt = S_WRITE;
      S_WRITE:   state_nxt = last_word ? S_DONE : S_COLLECT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state == S_COLLECT);
    mem_ren     = 1'b0;
    cpu_reset_n = reset & done;
    state_dbg   = state;
  end

  // Registered outputs are loaded from next-state so mem_wen/busy line up with the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_wen  <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      base_q   <= '0;
      num_q    <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      shift_q  <= '0;
    end else begin
      mem_wen <= (state_nxt == S_WRITE);
      busy    <= (state_nxt == S_COLLECT) || (state_nxt == S_WRITE);
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            error    <= range_bad && (num_words != '0);
            done     <= (num_words == '0);
            base_q   <= base_addr;
            num_q    <= num_words;
            word_cnt <= '0;
            byte_cnt <= '0;
          end
        end
        S_COLLECT: begin
          if (accept) begin
            shift_q  <= {shift_q[15:0], in_byte};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_din  <= {shift_q, in_byte};
              mem_addr <= {{(32-ADDR_W){1'b0}}, word_addr};
            end
          end
        end
        S_WRITE: begin
          word_cnt <= word_cnt + (ADDR_W+1)'(1);
          if (last_word) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_program_loader.sv
// Directed bench for mem_program_loader: byte driver, negedge write monitor feeding a
// scoreboard and a memory model, immediate-assertion checks, one summary line.
module tb_mem_program_loader;
  localparam int ADDR_W = 10;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   num_words = '0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_byte = '0;
  logic              in_ready, mem_wen, mem_ren, busy, done, error, cpu_reset_n;
  logic [31:0]       mem_addr, mem_din;
  logic [1:0]        state_dbg;

  always #5 clock = ~clock;

  mem_program_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(1024)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .num_words(num_words), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_din(mem_din),
    .busy(busy), .done(done), .error(error), .cpu_reset_n(cpu_reset_n), .state_dbg(state_dbg)
  );

  int          checks = 0;
  int          errors = 0;
  int          wen_cnt = 0;
  int          inv_viol = 0;
  int          cyc = 0;
  int          t0, w0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  logic [31:0] mem_model [0:1023];
  logic        written [0:1023];
  logic [31:0] words [0:3];

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (mem_wen) begin
      got_q.push_back({mem_addr, mem_din});
      mem_model[mem_addr[9:0]] = mem_din;
      written[mem_addr[9:0]] = 1'b1;
      wen_cnt++;
    end
    if ((mem_wen && mem_ren) || (mem_addr[31:10] != '0)) inv_viol++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input int base, input int num);
    start = 1'b1;
    base_addr = ADDR_W'(base);
    num_words = (ADDR_W+1)'(num);
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gaps);
    int guard;
    in_valid = 1'b0;
    repeat (gaps) step();
    in_valid = 1'b1;
    in_byte = b;
    guard = 0;
    while (!in_ready && guard < 40) begin
      step();
      guard++;
    end
    if (guard >= 40) check("in_ready_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input int addr, input logic [31:0] w, input bit rnd);
    exp_q.push_back({32'(addr), w});
    for (int k = 0; k < 4; k++)
      send_byte(w[31-8*k -: 8], rnd ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic wait_done(input string tag);
    int guard;
    guard = 0;
    while (!done && guard < 40) begin
      step();
      guard++;
    end
    check(tag, done, 1);
  endtask

  task automatic sb_check(input string tag);
    logic [63:0] e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) g = '1;
      else g = got_q.pop_front();
      check(tag, g, e);
    end
    check({tag, "_extra"}, 64'(got_q.size()), 0);
    got_q.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_mem_wen"}, mem_wen, 0);
    check({tag, "_mem_ren"}, mem_ren, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_din"}, mem_din, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_cpu_reset_n"}, cpu_reset_n, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_model[i] = '0;
      written[i] = 1'b0;
    end

    // 1: reset held, then released with no start
    repeat (3) step();
    check_idle("rst_held");
    reset = 1'b1;
    repeat (5) step();
    check_idle("rst_released");
    check("rst_no_wen", wen_cnt, 0);

    // 2: two words back-to-back from base 0
    do_start(0, 2);
    t0 = cyc;
    check("t2_busy", busy, 1);
    check("t2_in_ready", in_ready, 1);
    send_word(0, 32'h1234_5678, 1'b0);
    send_word(1, 32'h9ABC_DEF0, 1'b0);
    check("t2_wen_last", mem_wen, 1);
    check("t2_addr_last", mem_addr, 1);
    check("t2_din_last", mem_din, 32'h9ABC_DEF0);
    check("t2_done_early", done, 0);
    step();
    check("t2_done", done, 1);
    check("t2_latency", cyc - t0, 10);
    check("t2_cpu_reset_n", cpu_reset_n, 1);
    check("t2_busy_end", busy, 0);
    check("t2_wen_end", mem_wen, 0);
    check("t2_addr_hold", mem_addr, 1);
    check("t2_state", state_dbg, 3);
    sb_check("t2_sb");

    // 3: range overflow rejected, then the exact top-of-memory load
    w0 = wen_cnt;
    do_start(1020, 8);
    check("t3_error", error, 1);
    check("t3_state", state_dbg, 0);
    check("t3_in_ready", in_ready, 0);
    check("t3_done_cleared", done, 0);
    check("t3_cpu_held", cpu_reset_n, 0);
    repeat (4) step();
    check("t3_no_wen", wen_cnt - w0, 0);
    do_start(1020, 4);
    check("t3_error_cleared", error, 0);
    check("t3_state_collect", state_dbg, 1);
    words[0] = 32'hA1B2_C3D4; words[1] = 32'h0102_0304;
    words[2] = 32'hFFEE_DDCC; words[3] = 32'h5566_7788;
    for (int i = 0; i < 4; i++) send_word(1020 + i, words[i], 1'b0);
    wait_done("t3_done");
    check("t3_last_addr", mem_addr, 1023);
    sb_check("t3_sb");

    // 4: zero-length load, then randomly gapped vs back-to-back loads
    w0 = wen_cnt;
    do_start(7, 0);
    check("t4_done_now", done, 1);
    check("t4_state", state_dbg, 3);
    check("t4_busy", busy, 0);
    check("t4_no_wen", wen_cnt - w0, 0);
    words[0] = 32'hDEAD_BEEF; words[1] = 32'h0BAD_F00D; words[2] = 32'hC001_D00D;
    w0 = wen_cnt;
    do_start(100, 3);
    for (int i = 0; i < 3; i++) send_word(100 + i, words[i], 1'b1);
    wait_done("t4_done_rand");
    check("t4_wen_count", wen_cnt - w0, 3);
    sb_check("t4_sb_rand");
    do_start(200, 3);
    for (int i = 0; i < 3; i++) send_word(200 + i, words[i], 1'b0);
    wait_done("t4_done_b2b");
    sb_check("t4_sb_b2b");
    for (int i = 0; i < 3; i++) begin
      check("t4_same_mem", mem_model[100 + i], mem_model[200 + i]);
      check("t4_mem_val", mem_model[100 + i], words[i]);
    end

    // 5: reset after six bytes of a three-word load
    do_start(300, 3);
    send_word(300, 32'h1111_2222, 1'b0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    reset = 1'b0;
    #1;
    check("t5_state", state_dbg, 0);
    check("t5_done", done, 0);
    check("t5_cpu_held", cpu_reset_n, 0);
    check("t5_busy", busy, 0);
    check("t5_in_ready", in_ready, 0);
    repeat (2) step();
    check("t5_word0", mem_model[300], 32'h1111_2222);
    check("t5_word1_absent", written[301], 0);
    sb_check("t5_sb_partial");
    reset = 1'b1;
    step();
    do_start(300, 3);
    words[0] = 32'h3344_5566; words[1] = 32'h7788_99AA; words[2] = 32'hBBCC_DDEE;
    for (int i = 0; i < 3; i++) send_word(300 + i, words[i], 1'b0);
    wait_done("t5_done_reload");
    check("t5_cpu_run", cpu_reset_n, 1);
    check("t5_word2", mem_model[302], 32'hBBCC_DDEE);
    sb_check("t5_sb_reload");

    // 6: start ignored mid-load, then reload from DONE at base 5
    do_start(400, 2);
    exp_q.push_back({32'd400, 32'hCAFE_BABE});
    send_byte(8'hCA, 0);
    send_byte(8'hFE, 0);
    start = 1'b1;
    base_addr = 10'd0;
    num_words = 11'd1;
    step();
    start = 1'b0;
    check("t6_still_collect", state_dbg, 1);
    check("t6_still_busy", busy, 1);
    send_byte(8'hBA, 0);
    send_byte(8'hBE, 0);
    send_word(401, 32'h0F1E_2D3C, 1'b0);
    wait_done("t6_done_first");
    sb_check("t6_sb_first");
    do_start(5, 1);
    check("t6_done_drop", done, 0);
    check("t6_cpu_reheld", cpu_reset_n, 0);
    check("t6_busy", busy, 1);
    send_word(5, 32'h4B5A_6978, 1'b0);
    wait_done("t6_done_second");
    check("t6_cpu_run", cpu_reset_n, 1);
    sb_check("t6_sb_second");

    check("invariants", inv_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
